// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINISH,
    RUN
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // A load length spans 0..DEPTH inclusive, so it needs one bit more than a word index.
  localparam int LEN_EXTRA_W = 1;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Byte-stream, instruction-memory and core-control signals of the boot loader.
interface imem_boot_ctrl_if
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 5
);

  logic                          start;
  logic [ADDR_W+LEN_EXTRA_W-1:0] load_len;
  logic                          byte_valid;
  logic [7:0]                    byte_data;
  logic                          byte_ready;
  logic [31:0]                   cpu_pc;
  logic [31:0]                   imem_addr;
  logic [31:0]                   imem_wreg;
  logic [31:0]                   imem_wdata;
  logic                          imem_we;
  logic                          cpu_stall;
  logic                          busy;
  logic                          done;

  modport master (
    output start, load_len, byte_valid, byte_data, cpu_pc,
    input  byte_ready, imem_addr, imem_wreg, imem_wdata, imem_we, cpu_stall, busy, done
  );

  modport slave (
    input  start, load_len, byte_valid, byte_data, cpu_pc,
    output byte_ready, imem_addr, imem_wreg, imem_wdata, imem_we, cpu_stall, busy, done
  );

endinterface

// File: rtl/imem_boot_ctrl_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; the fourth byte is used live
// together with the three held bytes, so the word is ready in the cycle it completes.
module byte_packer
  import imem_boot_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        accept,
  input  logic        clear,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int                CNT_W     = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] byte_idx;
  logic [23:0]      held;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_idx <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + CNT_ONE;
    end
  end

  // Shift right so the earliest byte ends up in the least significant lane.
  always_ff @(posedge clock) begin
    if (accept) begin
      held <= {data_byte, held[23:8]};
    end
  end

  assign word       = {data_byte, held};
  assign word_valid = accept && (byte_idx == LAST_BYTE);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/load controller: streams bytes into instruction memory while stalling the core,
// then releases the core and forwards its PC as a word index.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
)(
  input logic             clock,
  input logic             reset,
  imem_boot_ctrl_if.slave bus
);

  localparam int                LEN_W   = ADDR_W + LEN_EXTRA_W;
  localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] wreg;
  logic [31:0]       wdata;
  logic              byte_ready;
  logic              we;
  logic              stall;
  logic              busy;
  logic              done;

  logic              accept;
  logic              clear;
  logic              word_valid;
  logic [31:0]       word;
  logic [LEN_W-1:0]  start_len;
  logic              unused_pc;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req);
    return (req > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : req;
  endfunction

  assign accept    = byte_ready && bus.byte_valid;
  assign clear     = bus.start && ((state == IDLE) || (state == RUN));
  assign start_len = clamp_len(bus.load_len);

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .accept     (accept),
    .clear      (clear),
    .data_byte  (bus.byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      word_idx   <= '0;
      wreg       <= '0;
      wdata      <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      stall      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (bus.start) begin
            len      <= start_len;
            word_idx <= '0;
            if (start_len == '0) begin
              state <= RUN;
              done  <= 1'b1;
              stall <= 1'b0;
            end else begin
              state      <= LOAD;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              stall      <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (word_valid) begin
            we       <= 1'b1;
            wreg     <= word_idx;
            wdata    <= word;
            word_idx <= word_idx + IDX_ONE;
            if ((LEN_W'(word_idx) + LEN_ONE) == len) begin
              state      <= FINISH;
              byte_ready <= 1'b0;
            end
          end
        end
        FINISH: begin
          state <= RUN;
          done  <= 1'b1;
          stall <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Byte PC to word index; the low two bits select a byte within the word and are dropped.
  assign bus.imem_addr  = {2'b00, bus.cpu_pc[31:2]};
  assign unused_pc      = ^bus.cpu_pc[1:0];

  assign bus.byte_ready = byte_ready;
  assign bus.imem_we    = we;
  assign bus.imem_wreg  = {{(32-ADDR_W){1'b0}}, wreg};
  assign bus.imem_wdata = wdata;
  assign bus.cpu_stall  = stall;
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule
